alu_arbiter: RTL and testbench

- Shares the single combinational 34-bit ALU (ops ADD/SUB/MUL/DIV, flags OverFlow/Carry/Zero/Negative) between NREQ requesters, e.g. the execute stage, address generation and a debug port.
- Arbitrates round-robin, registers operands, drives the ALU for one cycle, captures result and flags, and returns them with the winner's ID over a valid/ready response channel.
- Sits between the requesters and the ALU instance in the processor datapath.

---
 rtl/alu_arb_pkg.sv | 24 ++
 rtl/alu_arbiter_rr_arbiter.sv | 36 +++
 rtl/alu_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared constants for the ALU arbiter: ALU op codes, FSM states and
// the bit positions inside the {N, Z, C, V} flag nibble.
package alu_arb_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  // Flag pattern returned for a trapped divide by zero (Zero only)
  localparam logic [3:0] FLAGS_DIVZERO = 4'b0100;

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first asserted request at or
// after ptr_i (wrapping modulo NREQ) wins. grant_o is one-hot and
// grant_idx_o is its index; both are zero when nothing is requested.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  grant_idx_o
);

  int   idx;
  logic found;
  logic hit;

  // Walk the requesters in priority order starting at the pointer
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = 0;
    hit         = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_i) + k >= NREQ) ? int'(ptr_i) + k - NREQ : int'(ptr_i) + k;
      for (int j = 0; j < NREQ; j++) begin
        hit         = !found && (j == idx) && req_i[j];
        grant_o[j]  = grant_o[j] | hit;
        grant_idx_o = hit ? IDW'(j) : grant_idx_o;
        found       = found | hit;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end for a single shared combinational ALU.
// One operation at a time: IDLE (arbitrate/accept) -> EXEC (drive ALU)
// -> RESP (hold result until consumed).
// Optional build macro ALU_ARB_DIVZERO_TRAP_EN: a divide by zero is
// answered directly from IDLE with result 0, flags Zero and resp_err=1,
// without touching the ALU inputs.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int W    = 34,
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*2-1:0] req_op,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [W-1:0]      resp_result,
  output logic [3:0]        resp_flags,
  output logic              resp_err,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  output logic [1:0]        alu_ctrl,
  input  logic [W-1:0]      alu_result,
  input  logic              alu_ovf,
  input  logic              alu_carry,
  input  logic              alu_zero,
  input  logic              alu_neg,
  output logic              busy
);

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [1:0]     alu_ctrl_q, alu_ctrl_d;
  logic [W-1:0]   result_q, result_d;
  logic [3:0]     flags_q, flags_d;

  logic [NREQ-1:0] grant_s;
  logic [IDW-1:0]  grant_idx_s;
  logic [IDW-1:0]  ptr_next_s;
  logic [W-1:0]    sel_a_s, sel_b_s;
  logic [1:0]      sel_op_s;
  logic [3:0]      alu_flags_s;
  logic            accept_s;
  logic            trap_s;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .grant_o     (grant_s),
    .grant_idx_o (grant_idx_s)
  );

  // Grant is offered only while idle and never while reset is applied
  always_comb begin
    if ((state_q == IDLE) && rst_n) begin
      req_ready = grant_s;
    end else begin
      req_ready = '0;
    end
  end

  assign accept_s   = (state_q == IDLE) && (|req_valid);
  assign ptr_next_s = (grant_idx_s == IDW'(NREQ - 1)) ? '0 : grant_idx_s + IDW'(1);

  // One-hot mux of the winning requester's operands
  always_comb begin
    sel_a_s  = '0;
    sel_b_s  = '0;
    sel_op_s = '0;
    for (int j = 0; j < NREQ; j++) begin
      sel_a_s  = sel_a_s  | ({W{grant_s[j]}} & req_a[j*W +: W]);
      sel_b_s  = sel_b_s  | ({W{grant_s[j]}} & req_b[j*W +: W]);
      sel_op_s = sel_op_s | ({2{grant_s[j]}} & req_op[j*2 +: 2]);
    end
  end

  // Pack the ALU flag wires into the {N, Z, C, V} nibble
  always_comb begin
    alu_flags_s        = '0;
    alu_flags_s[FLG_N] = alu_neg;
    alu_flags_s[FLG_Z] = alu_zero;
    alu_flags_s[FLG_C] = alu_carry;
    alu_flags_s[FLG_V] = alu_ovf;
  end

  // Decide whether the winning request is a trapped divide by zero
  always_comb begin
`ifdef ALU_ARB_DIVZERO_TRAP_EN
    trap_s = (sel_op_s == OP_DIV) && (sel_b_s == '0);
`else
    trap_s = 1'b0;
`endif
  end

  // Next-state and datapath update; everything holds unless changed
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_ctrl_d = alu_ctrl_q;
    result_d   = result_q;
    flags_d    = flags_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          id_d  = grant_idx_s;
          ptr_d = ptr_next_s;
          if (trap_s) begin
            result_d = '0;
            flags_d  = FLAGS_DIVZERO;
            state_d  = RESP;
          end else begin
            alu_a_d    = sel_a_s;
            alu_b_d    = sel_b_s;
            alu_ctrl_d = sel_op_s;
            state_d    = EXEC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        result_d = alu_result;
        flags_d  = alu_flags_s;
        state_d  = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      id_q       <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctrl_q <= 2'b00;
      result_q   <= '0;
      flags_q    <= 4'b0000;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_ctrl_q <= alu_ctrl_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
    end
  end

`ifdef ALU_ARB_DIVZERO_TRAP_EN
  logic err_q, err_d;

  // The trap flag is decided at accept and travels with the response
  always_comb begin
    if (accept_s) begin
      err_d = trap_s;
    end else begin
      err_d = err_q;
    end
  end

  // Trap flag register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif

  assign resp_valid  = (state_q == RESP);
  assign resp_id     = id_q;
  assign resp_result = result_q;
  assign resp_flags  = flags_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_ctrl    = alu_ctrl_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised bench for alu_arbiter with a behavioural ALU attached and a
// transaction-level reference model (pending set + round-robin pointer).
module tb_alu_arbiter;

  localparam int W    = 34;
  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [NREQ*2-1:0] req_op;
  logic              resp_valid, resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [W-1:0]      resp_result;
  logic [3:0]        resp_flags;
  logic              resp_err;
  logic [W-1:0]      alu_a, alu_b, alu_result;
  logic [1:0]        alu_ctrl;
  logic              alu_ovf, alu_carry, alu_zero, alu_neg;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [W-1:0] ma [NREQ];
  logic [W-1:0] mb [NREQ];
  logic [1:0]   mop[NREQ];
  bit           pend[NREQ];
  int           ptr;

  logic [W-1:0]   r_res;
  logic [IDW-1:0] r_id;
  logic [3:0]     r_flg;
  logic           r_err;

  always #5 clk = ~clk;

  alu_arbiter #(.W(W), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result),
    .resp_flags(resp_flags), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_ovf(alu_ovf), .alu_carry(alu_carry),
    .alu_zero(alu_zero), .alu_neg(alu_neg), .busy(busy)
  );

  // Behavioural ALU: returns {N, Z, C, V, result}
  function automatic logic [W+3:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] op);
    logic [W:0]   wide;
    logic [W-1:0] r;
    logic         c, v;
    c = 1'b0; v = 1'b0; wide = '0;
    case (op)
      2'b00: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[W-1:0]; c = wide[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      2'b01: begin
        wide = {1'b0, a} - {1'b0, b};
        r = wide[W-1:0]; c = wide[W];
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      2'b10:   r = a * b;
      default: r = (b == '0) ? '1 : a / b;
    endcase
    return {r[W-1], (r == '0), c, v, r};
  endfunction

  // The ALU reacts combinationally to whatever the arbiter drives
  always_comb {alu_neg, alu_zero, alu_carry, alu_ovf, alu_result} = alu_model(alu_a, alu_b, alu_ctrl);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_w();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[W-1:0];
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]       = pend[i];
      req_a[i*W +: W]    = ma[i];
      req_b[i*W +: W]    = mb[i];
      req_op[i*2 +: 2]   = mop[i];
    end
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] op);
    ma[i] = a; mb[i] = b; mop[i] = op; pend[i] = 1'b1;
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ptr = 0;
  endtask

  // One arbitration + response round, checked against the model
  task automatic serve(input int stall);
    int             w, lat;
    bit             trap;
    logic [W+3:0]   exp;
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (w < 0 && pend[(ptr + k) % NREQ]) w = (ptr + k) % NREQ;
    end
    @(negedge clk);
    chk("busy_idle", busy, 0);
    if (w < 0) begin
      chk("grant_none", req_ready, 0);
      @(posedge clk); #1;
    end else begin
      chk("grant", req_ready, 64'd1 << w);
      exp  = alu_model(ma[w], mb[w], mop[w]);
      trap = 1'b0;
`ifdef ALU_ARB_DIVZERO_TRAP_EN
      if (mop[w] == 2'b11 && mb[w] == '0) begin
        trap = 1'b1;
        exp  = {4'b0100, {W{1'b0}}};
      end
`endif
      @(posedge clk); #1;
      pend[w] = 1'b0;
      ptr = (w + 1) % NREQ;
      drive();
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
        if (!resp_valid) chk("ready_in_exec", req_ready, 0);
      end while (!resp_valid && lat < 8);
      chk("latency", lat, trap ? 2'd1 : 2'd2);
      chk("resp_id", resp_id, w);
      chk("resp_result", resp_result, exp[W-1:0]);
      chk("resp_flags", resp_flags, exp[W+3:W]);
      chk("resp_err", resp_err, trap);
      chk("busy_resp", busy, 1);
      r_res = resp_result; r_id = resp_id; r_flg = resp_flags; r_err = resp_err;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        chk("hold_valid", resp_valid, 1);
        chk("hold_result", resp_result, exp[W-1:0]);
        chk("hold_id", resp_id, w);
        chk("stall_ready", req_ready, 0);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
    end
  endtask

  // Random refill of idle requesters; pending ones may withdraw
  task automatic refresh();
    for (int i = 0; i < NREQ; i++) begin
      if (!pend[i]) begin
        if ($urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          mop[i]  = 2'($urandom_range(0, 3));
          ma[i]   = rnd_w();
          mb[i]   = rnd_w();
          if ($urandom_range(0, 3) == 0) mb[i] = ma[i];
          if (mop[i] == 2'b10) begin
            ma[i] = W'($urandom_range(0, 1 << 20));
          end
          if (mop[i] == 2'b11 && $urandom_range(0, 2) == 0) mb[i] = '0;
        end
      end else if ($urandom_range(0, 9) == 0) begin
        pend[i] = 1'b0;
      end
    end
    drive();
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      ma[i] = '0; mb[i] = '0; mop[i] = 2'b00; pend[i] = 1'b0;
    end
    ptr = 0;
    resp_ready = 1'b0;
    drive();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    chk("rst_result", resp_result, 0);
    chk("rst_flags", resp_flags, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single add
    set_req(0, 34'd10, 34'd5, 2'b00);
    serve(0);
    chk("add_result", r_res, 15);
    chk("add_id", r_id, 0);
    chk("add_flags", r_flg, 0);

    // Simultaneous requests from reset
    do_reset();
    set_req(0, 34'd20, 34'd15, 2'b01);
    set_req(1, 34'd4, 34'd3, 2'b10);
    serve(0);
    chk("sim_id0", r_id, 0);
    chk("sim_res0", r_res, 5);
    serve(0);
    chk("sim_id1", r_id, 1);
    chk("sim_res1", r_res, 12);
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < NREQ; i++) pend[i] = 1'b1;
      drive();
      serve(0);
      chk("alternate_id", r_id, n % 2);
    end

    // Backpressure on a divide, with another requester waiting
    set_req(0, 34'd20, 34'd5, 2'b11);
    set_req(1, 34'd1, 34'd2, 2'b00);
    serve(5);
    chk("bp_result", r_res, 4);
    serve(0);
    chk("bp_next_id", r_id, 1);

    // Flag passthrough with carry out
    set_req(0, 34'h3FFFFFFFF, 34'h3FFFFFFFF, 2'b00);
    serve(1);
    chk("flag_result", r_res, 34'h3FFFFFFFE);
    chk("flag_carry", r_flg[1], 1);

    // Divide by zero
    set_req(1, 34'd50, 34'd0, 2'b11);
    serve(0);
`ifdef ALU_ARB_DIVZERO_TRAP_EN
    chk("dz_err", r_err, 1);
    chk("dz_result", r_res, 0);
    chk("dz_flags", r_flg, 4'b0100);
`else
    chk("dz_err", r_err, 0);
    chk("dz_result", r_res, 34'h3FFFFFFFF);
`endif

    // Randomised traffic
    for (int n = 0; n < 200; n++) begin
      if (n % 25 == 0) begin
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        drive();
      end else begin
        refresh();
      end
      serve(($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    // Reset during EXEC aborts the op and returns the pointer to 0
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    set_req(0, 34'h123, 34'h456, 2'b00);
    ptr = 0;
    @(negedge clk);
    if (req_ready != 2'b01) begin
      @(posedge clk); #1;
      set_req(1, 34'h1, 34'h1, 2'b00);
      @(negedge clk);
    end
    chk("abort_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    rst_n = 1'b0;
    set_req(0, 34'h22, 34'h33, 2'b00);
    set_req(1, 34'h44, 34'h55, 2'b01);
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_valid", resp_valid, 0);
    chk("abort_ready", req_ready, 0);
    chk("abort_alu_a", alu_a, 0);
    chk("abort_alu_b", alu_b, 0);
    chk("abort_result", resp_result, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    ptr = 0;
    serve(0);
    chk("abort_ptr0", r_id, 0);
    chk("abort_res", r_res, 34'h55);
    serve(0);
    chk("abort_id1", r_id, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
